// File: rtl/diap_select.sv
// diap_select: auto-ranging controller; coarse passes step each channel's range code, then one full pass is published.
//   in : clk, rst (sync, active high), start, adc_complete (edge used), adc_data_1/2
//   out: start_cycle_conv, read_diapason, diap_1/2, result_1/2, result_diap_1/2,
//        overrange_1/2, result_valid, busy
module diap_select #(
  parameter int DATA_WIDTH = 24,
  parameter int DIAP_WIDTH = 2,
  parameter logic [DATA_WIDTH-1:0] DIAP_THR_HI = 24'h03C000,
  parameter logic [DATA_WIDTH-1:0] DIAP_THR_LO = 24'h003000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int SETTLE_CNT_WIDTH = 10,
  parameter int DIAP_MAX_ITER = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  adc_complete,
  input  logic [DATA_WIDTH-1:0] adc_data_1,
  input  logic [DATA_WIDTH-1:0] adc_data_2,
  output logic                  start_cycle_conv,
  output logic                  read_diapason,
  output logic [DIAP_WIDTH-1:0] diap_1,
  output logic [DIAP_WIDTH-1:0] diap_2,
  output logic [DATA_WIDTH-1:0] result_1,
  output logic [DATA_WIDTH-1:0] result_2,
  output logic [DIAP_WIDTH-1:0] result_diap_1,
  output logic [DIAP_WIDTH-1:0] result_diap_2,
  output logic                  overrange_1,
  output logic                  overrange_2,
  output logic                  result_valid,
  output logic                  busy
);
  localparam logic [DIAP_WIDTH-1:0] DIAP_MAX = '1;
  localparam int ITER_W = $clog2(DIAP_MAX_ITER + 1);
  typedef enum logic [2:0] {
    IDLE, COARSE_START, COARSE_WAIT, EVALUATE, SETTLE, FULL_START, FULL_WAIT, DONE
  } state_t;
  state_t state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [SETTLE_CNT_WIDTH-1:0] settle_q, settle_d;
  logic comp_prev_q, comp_edge, at_limit, settle_done;
  logic [DIAP_WIDTH-1:0] diap_1_q, diap_1_d, diap_2_q, diap_2_d;
  logic [DIAP_WIDTH-1:0] result_diap_1_q, result_diap_1_d, result_diap_2_q, result_diap_2_d;
  logic [DATA_WIDTH-1:0] result_1_q, result_1_d, result_2_q, result_2_d;
  logic overrange_1_q, overrange_1_d, overrange_2_q, overrange_2_d;
  logic start_cycle_conv_q, start_cycle_conv_d, read_diapason_q, read_diapason_d;
  logic result_valid_q, result_valid_d, busy_q, busy_d;
  function automatic logic [DIAP_WIDTH-1:0] step(input logic [DATA_WIDTH-1:0] d,
                                                 input logic [DIAP_WIDTH-1:0] c);
    return (d >= DIAP_THR_HI && c != DIAP_MAX) ? c + 1'b1 :
           (d < DIAP_THR_LO && c != '0) ? c - 1'b1 : c;
  endfunction
  assign comp_edge   = adc_complete & ~comp_prev_q;
  assign at_limit    = iter_q >= ITER_W'(DIAP_MAX_ITER);
  assign settle_done = settle_q == SETTLE_CNT_WIDTH'(SETTLE_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    iter_d = iter_q;
    settle_d = settle_q;
    diap_1_d = diap_1_q;
    diap_2_d = diap_2_q;
    result_1_d = result_1_q;
    result_2_d = result_2_q;
    result_diap_1_d = result_diap_1_q;
    result_diap_2_d = result_diap_2_q;
    overrange_1_d = overrange_1_q;
    overrange_2_d = overrange_2_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = COARSE_START;
        iter_d = '0;
      end
      COARSE_START: begin
        iter_d = iter_q + 1'b1;
        state_d = COARSE_WAIT;
      end
      COARSE_WAIT: state_d = comp_edge ? EVALUATE : COARSE_WAIT;
      EVALUATE: begin
        diap_1_d = step(adc_data_1, diap_1_q);
        diap_2_d = step(adc_data_2, diap_2_q);
        state_d = (diap_1_d != diap_1_q || diap_2_d != diap_2_q) ? SETTLE : FULL_START;
      end
      SETTLE: begin
        settle_d = settle_done ? '0 : settle_q + 1'b1;
        state_d = !settle_done ? SETTLE : at_limit ? FULL_START : COARSE_START;
      end
      FULL_START: state_d = FULL_WAIT;
      // Results are captured on entry to DONE so they become visible together with result_valid;
      // adc_read holds the data stable while complete is high, so the captured values are those of DONE.
      FULL_WAIT: if (comp_edge) begin
        state_d = DONE;
        result_1_d = adc_data_1;
        result_2_d = adc_data_2;
        result_diap_1_d = diap_1_q;
        result_diap_2_d = diap_2_q;
        overrange_1_d = adc_data_1 >= DIAP_THR_HI && diap_1_q == DIAP_MAX;
        overrange_2_d = adc_data_2 >= DIAP_THR_HI && diap_2_q == DIAP_MAX;
      end
      default: state_d = IDLE;
    endcase
    // Registered outputs are decoded from the next state so they line up with the state they describe.
    start_cycle_conv_d = state_d inside {COARSE_START, FULL_START};
    read_diapason_d = (state_d inside {COARSE_START, COARSE_WAIT}) ? 1'b1 :
                      (state_d inside {FULL_START, FULL_WAIT}) ? 1'b0 : read_diapason_q;
    result_valid_d = state_d == DONE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      iter_q <= '0;
      settle_q <= '0;
      comp_prev_q <= 1'b0;
      diap_1_q <= DIAP_MAX;
      diap_2_q <= DIAP_MAX;
      result_1_q <= '0;
      result_2_q <= '0;
      result_diap_1_q <= '0;
      result_diap_2_q <= '0;
      overrange_1_q <= 1'b0;
      overrange_2_q <= 1'b0;
      start_cycle_conv_q <= 1'b0;
      read_diapason_q <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q <= iter_d;
      settle_q <= settle_d;
      comp_prev_q <= adc_complete;
      diap_1_q <= diap_1_d;
      diap_2_q <= diap_2_d;
      result_1_q <= result_1_d;
      result_2_q <= result_2_d;
      result_diap_1_q <= result_diap_1_d;
      result_diap_2_q <= result_diap_2_d;
      overrange_1_q <= overrange_1_d;
      overrange_2_q <= overrange_2_d;
      start_cycle_conv_q <= start_cycle_conv_d;
      read_diapason_q <= read_diapason_d;
      result_valid_q <= result_valid_d;
      busy_q <= busy_d;
    end
  end
  assign start_cycle_conv = start_cycle_conv_q;
  assign read_diapason = read_diapason_q;
  assign diap_1 = diap_1_q;
  assign diap_2 = diap_2_q;
  assign result_1 = result_1_q;
  assign result_2 = result_2_q;
  assign result_diap_1 = result_diap_1_q;
  assign result_diap_2 = result_diap_2_q;
  assign overrange_1 = overrange_1_q;
  assign overrange_2 = overrange_2_q;
  assign result_valid = result_valid_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_diap_select.sv
// tb_diap_select: randomized bench for diap_select with a behavioural auto-ranging model and an adc_read stand-in.
module tb_diap_select;
  localparam logic [23:0] HI = 24'h03C000;
  localparam logic [23:0] LO = 24'h003000;
  localparam int SC = 1000;
  logic clk = 0, rst = 1, start = 0, adc_complete = 0;
  logic [23:0] adc_data_1 = 0, adc_data_2 = 0;
  logic start_cycle_conv, read_diapason, overrange_1, overrange_2, result_valid, busy;
  logic [1:0] diap_1, diap_2, result_diap_1, result_diap_2;
  logic [23:0] result_1, result_2;
  diap_select dut (
    .clk(clk), .rst(rst), .start(start), .adc_complete(adc_complete),
    .adc_data_1(adc_data_1), .adc_data_2(adc_data_2),
    .start_cycle_conv(start_cycle_conv), .read_diapason(read_diapason),
    .diap_1(diap_1), .diap_2(diap_2), .result_1(result_1), .result_2(result_2),
    .result_diap_1(result_diap_1), .result_diap_2(result_diap_2),
    .overrange_1(overrange_1), .overrange_2(overrange_2),
    .result_valid(result_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  int pass_n = 0, total_n = 0;
  logic [23:0] cq1[4], cq2[4], f1, f2;
  int o_nc, o_nf, o_nv, nc_v, o_gap[8], gi, o_vlat, o_to;
  logic busy_after, scc_after, o_or1, o_or2;
  logic [23:0] o_r1, o_r2;
  logic [1:0] o_rd1, o_rd2;
  int m_d1 = 3, m_d2 = 3;
  int e_np, e_gap[4], e_d1, e_d2;
  bit e_or1, e_or2;
  logic [23:0] cand[10] = '{24'h000000, 24'h002FFF, 24'h003000, 24'h010000, 24'h020000,
                            24'h03BFFF, 24'h03C000, 24'h050000, 24'h800000, 24'h001234};
  function automatic int step_m(input logic [23:0] x, input int c);
    if (x >= HI) return (c < 3) ? c + 1 : c;
    if (x < LO) return (c > 0) ? c - 1 : c;
    return c;
  endfunction
  // Expected pass count, inter-pass gaps and final codes from the ranging rules.
  task automatic predict();
    int c1 = m_d1, c2 = m_d2, n1, n2;
    bit ch;
    e_np = 0;
    for (int p = 0; p < 4; p++) begin
      e_np++;
      n1 = step_m(cq1[p], c1);
      n2 = step_m(cq2[p], c2);
      ch = (n1 != c1) || (n2 != c2);
      e_gap[p] = ch ? SC + 2 : 2;
      c1 = n1;
      c2 = n2;
      if (!ch) break;
    end
    e_d1 = c1;
    e_d2 = c2;
    e_or1 = (f1 >= HI) && (c1 == 3);
    e_or2 = (f2 >= HI) && (c2 == 3);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    start = 0;
    adc_complete = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    m_d1 = 3;
    m_d2 = 3;
  endtask
  // One measurement: pulses start, answers every start_cycle_conv like adc_read, records what it sees.
  task automatic run_meas(input int hold, input bit keep);
    int t = 0, wl = 0, hc = 0, pi = 0, post = 0, last_raise = 0;
    bit is_c = 0, have_raise = 0;
    o_nc = 0; o_nf = 0; o_nv = 0; nc_v = -1; gi = 0; o_vlat = -1; o_to = 0;
    busy_after = 1'bx; scc_after = 1'bx;
    for (int i = 0; i < 8; i++) o_gap[i] = -1;
    @(negedge clk);
    start = 1;
    while (1) begin
      @(negedge clk);
      t++;
      if (t == 1 && !keep) start = 0;
      if (result_valid) begin
        o_nv++;
        if (o_nv == 1) begin
          nc_v = o_nc; o_vlat = t - last_raise;
          o_r1 = result_1; o_r2 = result_2; o_rd1 = result_diap_1; o_rd2 = result_diap_2;
          o_or1 = overrange_1; o_or2 = overrange_2;
        end
      end
      if (start_cycle_conv) begin
        if (have_raise && gi < 8) begin o_gap[gi] = t - last_raise; gi++; end
        have_raise = 0;
        if (read_diapason) o_nc++; else o_nf++;
        is_c = read_diapason;
        wl = $urandom_range(2, 6);
        if (hold == 0) begin adc_complete = 0; hc = 0; end
      end
      if (hc > 0) begin hc--; if (hc == 0) adc_complete = 0; end
      if (wl > 0) begin
        wl--;
        if (wl == 0) begin
          if (adc_complete) begin adc_complete = 0; hc = 0; wl = 1; end
          else begin
            adc_data_1 = is_c ? cq1[pi] : f1;
            adc_data_2 = is_c ? cq2[pi] : f2;
            if (is_c && pi < 3) pi++;
            adc_complete = 1;
            hc = (hold > 0) ? hold : $urandom_range(1, 4);
            last_raise = t;
            have_raise = 1;
          end
        end
      end
      if (o_nv > 0) begin
        post++;
        if (keep && post == 2) busy_after = busy;
        if (keep && post == 3) begin scc_after = start_cycle_conv; break; end
        if (!keep && post == 6) break;
      end
      if (t > 8000) begin o_to = 1; break; end
    end
    start = 0;
    if (!keep) adc_complete = 0;
  endtask
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total_n++; if (diap_1 !== 2'd3 || diap_2 !== 2'd3) $display("FAIL rst_diap: got %0d/%0d want 3/3", diap_1, diap_2); else pass_n++;
    total_n++; if (start_cycle_conv !== 0 || result_valid !== 0 || busy !== 0 || read_diapason !== 0)
      $display("FAIL rst_ctl: got scc=%b valid=%b busy=%b rd=%b want 0", start_cycle_conv, result_valid, busy, read_diapason); else pass_n++;
    total_n++; if (result_1 !== 0 || result_2 !== 0) $display("FAIL rst_result: got %h/%h want 0/0", result_1, result_2); else pass_n++;
    total_n++; if (result_diap_1 !== 0 || result_diap_2 !== 0 || overrange_1 !== 0 || overrange_2 !== 0)
      $display("FAIL rst_rdiap: got %0d/%0d or=%b%b want 0", result_diap_1, result_diap_2, overrange_1, overrange_2); else pass_n++;
  endtask
  task automatic test_in_window();
    for (int i = 0; i < 4; i++) begin cq1[i] = 24'h020000; cq2[i] = 24'h020000; end
    f1 = 24'h012345; f2 = 24'h00ABCD;
    run_meas(0, 0);
    total_n++; if (o_to !== 0) $display("FAIL win_timeout: got %0d want 0", o_to); else pass_n++;
    total_n++; if (o_nc !== 1 || o_nf !== 1) $display("FAIL win_pulses: got coarse=%0d full=%0d want 1/1", o_nc, o_nf); else pass_n++;
    total_n++; if (o_gap[0] !== 2) $display("FAIL win_nosettle: got %0d want 2", o_gap[0]); else pass_n++;
    total_n++; if (o_nv !== 1 || o_vlat !== 1) $display("FAIL win_valid: got n=%0d lat=%0d want 1/1", o_nv, o_vlat); else pass_n++;
    total_n++; if (o_r1 !== 24'h012345 || o_r2 !== 24'h00ABCD) $display("FAIL win_result: got %h/%h want 012345/00abcd", o_r1, o_r2); else pass_n++;
    total_n++; if (o_rd1 !== 3 || o_rd2 !== 3 || o_or1 !== 0 || o_or2 !== 0)
      $display("FAIL win_rdiap: got %0d/%0d or=%b%b want 3/3 or=00", o_rd1, o_rd2, o_or1, o_or2); else pass_n++;
  endtask
  task automatic test_step_down();
    cq1[0] = 24'h001000; cq2[0] = 24'h020000;
    for (int i = 1; i < 4; i++) begin cq1[i] = 24'h010000; cq2[i] = 24'h020000; end
    f1 = 24'h0000FF; f2 = 24'h030000;
    run_meas(0, 0);
    total_n++; if (o_nc !== 2 || o_nf !== 1) $display("FAIL step_pulses: got coarse=%0d full=%0d want 2/1", o_nc, o_nf); else pass_n++;
    total_n++; if (o_gap[0] !== SC + 2 || o_gap[1] !== 2) $display("FAIL step_gaps: got %0d/%0d want %0d/2", o_gap[0], o_gap[1], SC + 2); else pass_n++;
    total_n++; if (o_rd1 !== 2 || o_rd2 !== 3 || diap_1 !== 2 || diap_2 !== 3)
      $display("FAIL step_diap: got rd=%0d/%0d diap=%0d/%0d want 2/3", o_rd1, o_rd2, diap_1, diap_2); else pass_n++;
    m_d1 = 2;
  endtask
  task automatic test_iter_limit();
    do_reset();
    for (int i = 0; i < 4; i++) begin cq1[i] = 24'h000100; cq2[i] = 24'h000100; end
    f1 = 24'h000100; f2 = 24'h000100;
    run_meas(0, 0);
    total_n++; if (o_nc !== 4 || o_nf !== 1) $display("FAIL lim_dn_pulses: got coarse=%0d full=%0d want 4/1", o_nc, o_nf); else pass_n++;
    total_n++; if (o_gap[0] !== SC + 2 || o_gap[2] !== SC + 2 || o_gap[3] !== 2)
      $display("FAIL lim_dn_gaps: got %0d/%0d/%0d want %0d/%0d/2", o_gap[0], o_gap[2], o_gap[3], SC + 2, SC + 2); else pass_n++;
    total_n++; if (o_rd1 !== 0 || o_rd2 !== 0) $display("FAIL lim_dn_rdiap: got %0d/%0d want 0/0", o_rd1, o_rd2); else pass_n++;
    for (int i = 0; i < 4; i++) begin cq1[i] = 24'h03F000; cq2[i] = 24'h03F000; end
    f1 = 24'h03F000; f2 = 24'h03F000;
    run_meas(0, 0);
    total_n++; if (o_nc !== 4 || o_nf !== 1) $display("FAIL lim_up_pulses: got coarse=%0d full=%0d want 4/1", o_nc, o_nf); else pass_n++;
    total_n++; if (o_rd1 !== 3 || o_rd2 !== 3 || o_r1 !== 24'h03F000) $display("FAIL lim_up_result: got %0d/%0d %h want 3/3 03f000", o_rd1, o_rd2, o_r1); else pass_n++;
    total_n++; if (o_or1 !== 1 || o_or2 !== 1) $display("FAIL lim_up_overrange: got %b%b want 11", o_or1, o_or2); else pass_n++;
    m_d1 = 3; m_d2 = 3;
  endtask
  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) begin
        cq1[i] = ($urandom_range(0, 3) == 0) ? 24'($urandom) : cand[$urandom_range(0, 9)];
        cq2[i] = cand[$urandom_range(0, 9)];
      end
      f1 = cand[$urandom_range(0, 9)];
      f2 = 24'($urandom);
      predict();
      run_meas(0, 0);
      total_n++; if (o_to !== 0 || o_nc !== e_np || o_nf !== 1 || o_nv !== 1)
        $display("FAIL rnd%0d_flow: got to=%0d coarse=%0d full=%0d valid=%0d want 0/%0d/1/1", n, o_to, o_nc, o_nf, o_nv, e_np); else pass_n++;
      for (int p = 0; p < e_np; p++) begin
        total_n++; if (o_gap[p] !== e_gap[p]) $display("FAIL rnd%0d_gap%0d: got %0d want %0d", n, p, o_gap[p], e_gap[p]); else pass_n++;
      end
      total_n++; if (o_r1 !== f1 || o_r2 !== f2) $display("FAIL rnd%0d_result: got %h/%h want %h/%h", n, o_r1, o_r2, f1, f2); else pass_n++;
      total_n++; if (o_rd1 !== 2'(e_d1) || o_rd2 !== 2'(e_d2) || diap_1 !== 2'(e_d1) || diap_2 !== 2'(e_d2))
        $display("FAIL rnd%0d_diap: got rd=%0d/%0d diap=%0d/%0d want %0d/%0d", n, o_rd1, o_rd2, diap_1, diap_2, e_d1, e_d2); else pass_n++;
      total_n++; if (o_or1 !== e_or1 || o_or2 !== e_or2) $display("FAIL rnd%0d_overrange: got %b%b want %b%b", n, o_or1, o_or2, e_or1, e_or2); else pass_n++;
      m_d1 = e_d1; m_d2 = e_d2;
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin cq1[i] = 24'h020000; cq2[i] = 24'h020000; end
    f1 = 24'h015555; f2 = 24'h03F000;
    predict();
    run_meas(50, 1);
    total_n++; if (o_to !== 0 || nc_v !== 1 || o_gap[0] !== 2) $display("FAIL b2b_single_eval: got to=%0d coarse=%0d gap=%0d want 0/1/2", o_to, nc_v, o_gap[0]); else pass_n++;
    total_n++; if (o_vlat !== 1 || o_r1 !== f1 || o_r2 !== f2) $display("FAIL b2b_result: got lat=%0d %h/%h want 1 %h/%h", o_vlat, o_r1, o_r2, f1, f2); else pass_n++;
    total_n++; if (o_or2 !== e_or2) $display("FAIL b2b_overrange: got %b want %b", o_or2, e_or2); else pass_n++;
    total_n++; if (busy_after !== 0 || scc_after !== 1) $display("FAIL b2b_restart: got busy=%b scc=%b want 0/1", busy_after, scc_after); else pass_n++;
  endtask
  task automatic test_reset_mid();
    int k, nv = 0, np = 0;
    do_reset();
    @(negedge clk);
    start = 1;
    k = 0;
    while (!start_cycle_conv && k < 20) begin @(negedge clk); k++; end
    start = 0;
    adc_data_1 = 24'h020000; adc_data_2 = 24'h020000;
    repeat (3) @(negedge clk);
    adc_complete = 1;
    k = 0;
    while (!(start_cycle_conv && !read_diapason) && k < 20) begin @(negedge clk); k++; end
    total_n++; if (k >= 20) $display("FAIL mid_full_pulse: got none within 20 clocks want one"); else pass_n++;
    adc_complete = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    adc_complete = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (result_valid) nv++;
      if (start_cycle_conv) np++;
    end
    adc_complete = 0;
    total_n++; if (nv !== 0 || np !== 0) $display("FAIL mid_quiet: got valid=%0d pulses=%0d want 0/0", nv, np); else pass_n++;
    total_n++; if (busy !== 0 || diap_1 !== 3 || diap_2 !== 3 || result_1 !== 0 || result_2 !== 0)
      $display("FAIL mid_state: got busy=%b diap=%0d/%0d res=%h/%h want 0 3/3 0/0", busy, diap_1, diap_2, result_1, result_2); else pass_n++;
  endtask
  initial begin
    test_reset();
    test_in_window();
    test_step_down();
    test_iter_limit();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/diap_select.md
Name: diap_select

Overview:
- Auto-ranging controller directly downstream of the dual-channel ADC integrator (adc_read).
- Runs short coarse integrations (read_diapason=1) and steps each channel's gain-range code (diapason) until both readings are in window.
- Then runs one full integration (read_diapason=0) and publishes both results with their range codes, a valid pulse and overrange flags.
- Drives the analog range switches through diap_1/diap_2.

Parameters:
- DATA_WIDTH, 24, width of integrator results.
- DIAP_WIDTH, 2, width of range code; code 0 = most sensitive, DIAP_MAX = 2^DIAP_WIDTH-1 = least sensitive.
- DIAP_THR_HI, 24'h03C000, coarse reading >= this steps the range toward DIAP_MAX.
- DIAP_THR_LO, 24'h003000, coarse reading < this steps the range toward 0.
- SETTLE_CYCLES, 1000, clocks to wait after any range change before re-measuring.
- SETTLE_CNT_WIDTH, 10, settle counter width.
- DIAP_MAX_ITER, 4, maximum coarse passes per measurement.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  level; sampled in IDLE, begins a measurement
- adc_complete  in  1  adc_read complete (level); only its rising edge is used
- adc_data_1  in  DATA_WIDTH  adc_read data_out_1
- adc_data_2  in  DATA_WIDTH  adc_read data_out_2
- start_cycle_conv  out  1  one-clock pulse starting an adc_read cycle
- read_diapason  out  1  1 = coarse cycle, 0 = full cycle
- diap_1  out  DIAP_WIDTH  channel 1 range code to switches
- diap_2  out  DIAP_WIDTH  channel 2 range code to switches
- result_1  out  DATA_WIDTH  latched full result, channel 1
- result_2  out  DATA_WIDTH  latched full result, channel 2
- result_diap_1  out  DIAP_WIDTH  range code valid with result_1
- result_diap_2  out  DIAP_WIDTH  range code valid with result_2
- overrange_1  out  1  latched with result_1
- overrange_2  out  1  latched with result_2
- result_valid  out  1  one-clock pulse when results update
- busy  out  1  high in every state except IDLE

Behaviour:
- All outputs and state are registered; clk and rst only.
- Reset values:
  - diap_1 = diap_2 = DIAP_MAX (safe range).
  - results, result_diap_*, overrange_*, start_cycle_conv, read_diapason, result_valid, busy = 0.
  - Internal: state IDLE, iteration counter 0, settle counter 0, complete-edge register 0.
- Reset mid-operation: returns to IDLE with the values above; no result_valid is emitted.
- Range codes persist across measurements; each measurement starts from the last codes.
- Edge detection: comp_prev <= adc_complete every clock; edge = adc_complete & ~comp_prev. A held-high adc_complete yields exactly one edge.
- FSM states:
  - IDLE: if start=1 -> COARSE_START, clear iteration counter. Start in any other state is ignored.
  - COARSE_START:
    - start_cycle_conv=1 for this one clock, read_diapason=1; iteration counter +1.
    - -> COARSE_WAIT.
  - COARSE_WAIT: read_diapason held 1; on edge -> EVALUATE.
  - EVALUATE (one clock), per channel independently, unsigned compare:
    - data >= DIAP_THR_HI and diap < DIAP_MAX: diap+1.
    - else data < DIAP_THR_LO and diap > 0: diap-1.
    - else unchanged.
    - Codes saturate at 0 and DIAP_MAX and never wrap.
    - The new code appears on diap_* at the end of the EVALUATE clock.
    - If any code changed and iteration counter < DIAP_MAX_ITER -> SETTLE.
    - If any code changed and the iteration limit is reached -> SETTLE, then FULL_START.
    - If no code changed -> FULL_START, with no settle.
  - SETTLE: counts SETTLE_CYCLES clocks, then -> COARSE_START, or -> FULL_START when the iteration limit is reached.
  - FULL_START: start_cycle_conv=1 for one clock, read_diapason=0 -> FULL_WAIT.
  - FULL_WAIT: read_diapason held 0; on edge -> DONE.
  - DONE (one clock):
    - result_n <= adc_data_n; result_diap_n <= diap_n.
    - overrange_n <= (adc_data_n >= DIAP_THR_HI) & (diap_n == DIAP_MAX).
    - result_valid=1 for this clock -> IDLE.
- Latency:
  - start high in IDLE at clock T -> start_cycle_conv high at T+1.
  - Full-cycle complete edge seen at T2 -> result_valid high at T2+1.
- adc_data_* are sampled only in EVALUATE and DONE; adc_read holds them stable while complete is high.
- Edge in any state other than COARSE_WAIT/FULL_WAIT: ignored.

Test Plan:
- Reset (rst=1 for 3 clocks) -> diap_1=diap_2=3, start_cycle_conv=0, result_valid=0, busy=0; all results 0.
- In-window: start; coarse returns 0x20000/0x20000; full returns 0x12345/0x0ABCD -> exactly one coarse and one full start_cycle_conv pulse, no settle delay, result_1=0x12345, result_2=0x0ABCD, result_diap=3/3, overrange=0/0, result_valid for one clock.
- Step down: coarse pass 1 returns 0x01000/0x20000 -> diap_1=2, diap_2=3, SETTLE_CYCLES-clock gap before pass 2. Pass 2 returns 0x10000/0x20000 -> full cycle; result_diap_1=2.
- Iteration limit: coarse always returns 0x00100 from diap 3 -> codes 2,1,0 over passes 1-3. Pass 4 is at code 0, so no change -> full cycle. Repeat with always 0x3F000 from code 0 (codes 1,2,3,3) -> full follows pass 4; full value 0x3F000 -> overrange_1=overrange_2=1.
- Level/edge robustness: adc_complete held high 50 clocks -> a single EVALUATE. start held high throughout -> no restart until IDLE; the next measurement begins the clock after result_valid's IDLE cycle.
- Reset asserted in FULL_WAIT, then adc_complete edge -> no result_valid, outputs at reset values, diap=3/3, FSM in IDLE.
